// File: rtl/voter_tally.sv
// ---------------------------------------------------------------------------
// voter_tally
//   Sequential majority-vote tally unit. A session opens on start from
//   IDLE. The first ballot of each voter is latched during COLLECT. COLLECT
//   closes when every voter has voted or the timeout expires. COUNT then walks
//   the voters one per cycle. RESULT publishes a one-hot verdict and the yes
//   count, with a single-cycle done pulse.
//
//   Optional feature: define VOTER_QUORUM_EN to enable the quorum check.
//   When it is enabled, a session with fewer than QUORUM cast ballots reports
//   result=000 and raises no_quorum with done.
//
// Ports
//   clk         in   1         rising-edge clock
//   rst         in   1         synchronous active-high reset
//   start       in   1         open a session (sampled only in IDLE)
//   vote_valid  in   N_VOTERS  per-voter ballot strobe
//   vote_yes    in   N_VOTERS  per-voter ballot value, qualified by vote_valid
//   busy        out  1         high whenever not IDLE
//   done        out  1         one-cycle pulse, result/yes_count valid
//   result      out  3         one-hot {reject,tie,pass}; 000 = none/no quorum
//   yes_count   out  CW        yes ballots of last session
//   no_quorum   out  1         quorum failed (constant 0 without the macro)
// ---------------------------------------------------------------------------
module voter_tally #(
    parameter  int N_VOTERS = 4,
    parameter  int TIMEOUT  = 16,
    parameter  int QUORUM   = 3,
    localparam int CW       = $clog2(N_VOTERS + 1)
) (
    input  logic                clk,
    input  logic                rst,
    input  logic                start,
    input  logic [N_VOTERS-1:0] vote_valid,
    input  logic [N_VOTERS-1:0] vote_yes,
    output logic                busy,
    output logic                done,
    output logic [2:0]          result,
    output logic [CW-1:0]       yes_count,
    output logic                no_quorum
);

    localparam int TW = (TIMEOUT > 1) ? $clog2(TIMEOUT) : 1;
    localparam int IW = $clog2(N_VOTERS);

    localparam logic [TW-1:0] T_LAST  = TW'(TIMEOUT - 1);
    localparam logic [IW-1:0] I_LAST  = IW'(N_VOTERS - 1);
    localparam logic [CW:0]   NV_WIDE = (CW + 1)'(N_VOTERS);

    localparam logic [2:0] RES_REJECT = 3'b100;
    localparam logic [2:0] RES_TIE    = 3'b010;
    localparam logic [2:0] RES_PASS   = 3'b001;

    if (N_VOTERS < 2 || TIMEOUT < 1 || QUORUM < 0) begin : g_bad_param
        $error("voter_tally: illegal parameter combination");
    end

    typedef enum logic [1:0] {
        S_IDLE    = 2'd0,
        S_COLLECT = 2'd1,
        S_COUNT   = 2'd2,
        S_RESULT  = 2'd3
    } state_t;

    state_t              state_q,   state_d;
    logic [N_VOTERS-1:0] voted_q,   voted_d;
    logic [N_VOTERS-1:0] ballot_q,  ballot_d;
    logic [TW-1:0]       timer_q,   timer_d;
    logic [IW-1:0]       idx_q,     idx_d;
    logic [CW-1:0]       yes_acc_q, yes_acc_d;
    logic                done_q,    done_d;
    logic [2:0]          result_q,  result_d;
    logic [CW-1:0]       yes_cnt_q, yes_cnt_d;

    logic [N_VOTERS-1:0] new_vote;
    logic [CW:0]         yes_x2;
    logic [2:0]          verdict;

    // Only voters that have not voted yet may latch a ballot.
    assign new_vote = vote_valid & ~voted_q;
    assign yes_x2   = {yes_acc_q, 1'b0};

    always_comb begin
        if (yes_x2 < NV_WIDE)       verdict = RES_REJECT;
        else if (yes_x2 == NV_WIDE) verdict = RES_TIE;
        else                        verdict = RES_PASS;
    end

`ifdef VOTER_QUORUM_EN
    logic [CW-1:0] cast_acc_q, cast_acc_d;
    logic          nq_q,       nq_d;
    logic          quorum_fail;

    assign quorum_fail = ({{(32-CW){1'b0}}, cast_acc_q} < 32'(QUORUM));
`endif

    always_comb begin
        state_d   = state_q;
        voted_d   = voted_q;
        ballot_d  = ballot_q;
        timer_d   = timer_q;
        idx_d     = idx_q;
        yes_acc_d = yes_acc_q;
        done_d    = 1'b0;
        result_d  = result_q;
        yes_cnt_d = yes_cnt_q;
`ifdef VOTER_QUORUM_EN
        cast_acc_d = cast_acc_q;
        nq_d       = nq_q;
`endif
        unique case (state_q)
            S_IDLE: begin
                if (start) begin
                    state_d   = S_COLLECT;
                    voted_d   = '0;
                    ballot_d  = '0;
                    timer_d   = '0;
                    idx_d     = '0;
                    yes_acc_d = '0;
`ifdef VOTER_QUORUM_EN
                    cast_acc_d = '0;
`endif
                end
            end
            S_COLLECT: begin
                voted_d  = voted_q | vote_valid;
                ballot_d = (ballot_q & ~new_vote) | (vote_yes & new_vote);
                // Close on this edge if the strobes now complete the electorate.
                if ((&(voted_q | vote_valid)) || (timer_q == T_LAST)) begin
                    state_d = S_COUNT;
                    idx_d   = '0;
                end else begin
                    timer_d = timer_q + 1'b1;
                end
            end
            S_COUNT: begin
                // Abstentions (unvoted) contribute neither yes nor cast.
                yes_acc_d = yes_acc_q + CW'(ballot_q[idx_q] & voted_q[idx_q]);
`ifdef VOTER_QUORUM_EN
                cast_acc_d = cast_acc_q + CW'(voted_q[idx_q]);
`endif
                if (idx_q == I_LAST) state_d = S_RESULT;
                else                 idx_d   = idx_q + 1'b1;
            end
            S_RESULT: begin
                state_d   = S_IDLE;
                done_d    = 1'b1;
                yes_cnt_d = yes_acc_q;
                result_d  = verdict;
`ifdef VOTER_QUORUM_EN
                nq_d = quorum_fail;
                if (quorum_fail) result_d = 3'b000;
`endif
            end
            default: state_d = S_IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q   <= S_IDLE;
            voted_q   <= '0;
            ballot_q  <= '0;
            timer_q   <= '0;
            idx_q     <= '0;
            yes_acc_q <= '0;
            done_q    <= 1'b0;
            result_q  <= 3'b000;
            yes_cnt_q <= '0;
        end else begin
            state_q   <= state_d;
            voted_q   <= voted_d;
            ballot_q  <= ballot_d;
            timer_q   <= timer_d;
            idx_q     <= idx_d;
            yes_acc_q <= yes_acc_d;
            done_q    <= done_d;
            result_q  <= result_d;
            yes_cnt_q <= yes_cnt_d;
        end
    end

`ifdef VOTER_QUORUM_EN
    always_ff @(posedge clk) begin
        if (rst) begin
            cast_acc_q <= '0;
            nq_q       <= 1'b0;
        end else begin
            cast_acc_q <= cast_acc_d;
            nq_q       <= nq_d;
        end
    end

    assign no_quorum = nq_q;
`else
    assign no_quorum = 1'b0;
`endif

    assign busy      = (state_q != S_IDLE);
    assign done      = done_q;
    assign result    = result_q;
    assign yes_count = yes_cnt_q;

endmodule

// File: tb/tb_voter_tally.sv
// ---------------------------------------------------------------------------
// tb_voter_tally
//   Self-checking bench for voter_tally (N_VOTERS=4, TIMEOUT=16, QUORUM=3).
//   Table-driven sessions plus hand-written sequences for first-ballot
//   stickiness, start while busy, and reset in the middle of COUNT.
// ---------------------------------------------------------------------------
module tb_voter_tally;

`ifdef VOTER_QUORUM_EN
    localparam bit QEN = 1'b1;
`else
    localparam bit QEN = 1'b0;
`endif

    logic       clk = 1'b0;
    logic       rst;
    logic       start;
    logic [3:0] vote_valid;
    logic [3:0] vote_yes;
    logic       busy;
    logic       done;
    logic [2:0] result;
    logic [2:0] yes_count;
    logic       no_quorum;

    int total = 0;
    int bad   = 0;
    int cyc   = 0;

    voter_tally #(.N_VOTERS(4), .TIMEOUT(16), .QUORUM(3)) dut (
        .clk        (clk),
        .rst        (rst),
        .start      (start),
        .vote_valid (vote_valid),
        .vote_yes   (vote_yes),
        .busy       (busy),
        .done       (done),
        .result     (result),
        .yes_count  (yes_count),
        .no_quorum  (no_quorum)
    );

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    typedef struct {
        logic [3:0] valid;
        logic [3:0] yes;
        int         exp_yc;
        logic [2:0] exp_res;    // verdict without the quorum check
        logic [2:0] exp_res_q;  // verdict with the quorum check
        logic       exp_nq;
        int         exp_lat;    // edges from the start edge to the done edge
    } vec_t;

    vec_t tbl[9];

    task automatic chk(input string name, input int act, input int exp);
        total++;
        if (act != exp) begin
            bad++;
            $display("FAIL %s: got %0d expected %0d", name, act, exp);
        end
    endtask

    // Raise start for one edge. Return the cycle stamp of the start edge.
    task automatic open_session(output int t0);
        @(negedge clk);
        start = 1'b1;
        @(posedge clk);
        @(negedge clk);
        start = 1'b0;
        t0 = cyc;
    endtask

    // Wait, with a bound, until done is seen at a negedge.
    task automatic wait_done(input string name, output bit seen);
        seen = 1'b0;
        for (int k = 0; k < 60; k++) begin
            if (done) begin
                seen = 1'b1;
                break;
            end
            @(negedge clk);
        end
        if (!seen) chk({name, " done timeout"}, 0, 1);
    endtask

    task automatic run_vec(input vec_t v, input string name);
        int t0;
        bit seen;
        open_session(t0);
        chk({name, " busy"}, int'(busy), 1);
        vote_valid = v.valid;
        vote_yes   = v.yes;
        @(negedge clk);
        vote_valid = '0;
        vote_yes   = '0;
        wait_done(name, seen);
        if (seen) begin
            chk({name, " latency"}, cyc - t0, v.exp_lat);
            chk({name, " yes_count"}, int'(yes_count), v.exp_yc);
            chk({name, " result"}, int'(result), int'(QEN ? v.exp_res_q : v.exp_res));
            chk({name, " no_quorum"}, int'(no_quorum), int'(QEN ? v.exp_nq : 1'b0));
            @(negedge clk);
            chk({name, " done pulse"}, int'(done), 0);
            chk({name, " idle after"}, int'(busy), 0);
            chk({name, " result held"}, int'(yes_count), v.exp_yc);
        end
    endtask

    initial begin
        int  t0;
        int  ndone;
        int  lat;
        int  yc_s;
        int  res_s;
        bit  seen;

        //             valid    yes     yc res     res_q   nq  lat
        tbl[0] = '{4'b1111, 4'b1011, 3, 3'b001, 3'b001, 1'b0, 6};
        tbl[1] = '{4'b1111, 4'b0011, 2, 3'b010, 3'b010, 1'b0, 6};
        tbl[2] = '{4'b1111, 4'b0001, 1, 3'b100, 3'b100, 1'b0, 6};
        tbl[3] = '{4'b1111, 4'b1111, 4, 3'b001, 3'b001, 1'b0, 6};
        tbl[4] = '{4'b1111, 4'b0000, 0, 3'b100, 3'b100, 1'b0, 6};
        tbl[5] = '{4'b0001, 4'b0001, 1, 3'b100, 3'b000, 1'b1, 21};
        tbl[6] = '{4'b0111, 4'b0111, 3, 3'b001, 3'b001, 1'b0, 21};
        tbl[7] = '{4'b0101, 4'b1111, 2, 3'b010, 3'b000, 1'b1, 21};
        tbl[8] = '{4'b1101, 4'b0010, 0, 3'b100, 3'b100, 1'b0, 21};

        // Reset with start held high: start must be ignored.
        rst = 1'b1; start = 1'b1; vote_valid = '0; vote_yes = '0;
        @(posedge clk); @(posedge clk);
        @(negedge clk);
        chk("reset busy", int'(busy), 0);
        chk("reset done", int'(done), 0);
        chk("reset result", int'(result), 0);
        chk("reset yes_count", int'(yes_count), 0);
        chk("reset no_quorum", int'(no_quorum), 0);
        rst = 1'b0; start = 1'b0;
        @(negedge clk);
        chk("idle after reset", int'(busy), 0);

        for (int i = 0; i < 9; i++) run_vec(tbl[i], $sformatf("vec%0d", i));

        // Voter 2 votes no, then yes (ignored), then voters 0,1,3 vote yes.
        // The electorate completes at edge t+3. start pulsed in COUNT is ignored.
        open_session(t0);
        vote_valid = 4'b0100; vote_yes = 4'b0000;
        @(negedge clk);
        vote_valid = 4'b0100; vote_yes = 4'b0100;
        @(negedge clk);
        vote_valid = 4'b1011; vote_yes = 4'b1011;
        @(negedge clk);
        vote_valid = '0; vote_yes = '0;
        start = 1'b1;
        @(negedge clk);
        start = 1'b0;
        ndone = 0; lat = 0; yc_s = 0; res_s = 0;
        for (int k = 0; k < 30; k++) begin
            if (done) begin
                ndone++;
                lat = cyc - t0; yc_s = int'(yes_count); res_s = int'(result);
            end
            @(negedge clk);
        end
        chk("sticky done count", ndone, 1);
        chk("sticky latency", lat, 8);
        chk("sticky yes_count", yc_s, 3);
        chk("sticky result", res_s, 1);
        chk("no restart busy", int'(busy), 0);

        // Reset in the middle of COUNT: the session is aborted and no done is produced.
        open_session(t0);
        vote_valid = 4'b1111; vote_yes = 4'b1111;
        @(negedge clk);                       // after edge t+1: COUNT
        vote_valid = '0; vote_yes = '0;
        @(negedge clk);                       // after edge t+2: idx 1
        rst = 1'b1;
        @(negedge clk);
        rst = 1'b0;
        chk("midrst busy", int'(busy), 0);
        chk("midrst result", int'(result), 0);
        chk("midrst yes_count", int'(yes_count), 0);
        chk("midrst done", int'(done), 0);
        ndone = 0;
        for (int k = 0; k < 10; k++) begin
            if (done) ndone++;
            @(negedge clk);
        end
        chk("midrst no done", ndone, 0);
        run_vec(tbl[0], "after rst");

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

    // Absolute guard so the run ends even if a wait were to stall.
    initial begin
        #200000;
        $display("FAIL global timeout: got running expected finished");
        $fatal(1, "timeout");
    end

endmodule
